// File: rtl/gauss_fir_mod.sv
// gauss_fir_mod
//    Gaussian pulse-shaping FIR for the BTLE TX chain. Sits between the bit
//    upsampler and the FM/phase modulator. Each accepted upsampled bit is
//    mapped to +1/-1 and convolved with a symmetric FIR. Only the first half
//    of the coefficients is stored. At packet end the window is flushed with
//    masked (zero) taps, so a packet of N bits yields N+NUM_TAP-1 samples.
//
// Parameters
//    COEF_WIDTH  signed coefficient width
//    NUM_TAP     filter length (odd, 3..33)
//    OUT_WIDTH   signed output width
//
// Ports
//    clk, rst                  clock; asynchronous active-high reset
//    coef_wr_en/addr/data      coefficient write port (addr 0..NUM_COEF-1)
//    bit_in, bit_in_valid,
//    bit_in_last, bit_in_ready input bit stream with valid/ready handshake
//    out_sample, out_valid,
//    out_last, out_sat         filtered sample stream (1-cycle latency)
//    busy                      high whenever a packet is in progress
//
// Build option
//    GAUSS_FIR_SAT_EN  when defined, the sum is clamped to the output range
//                      and out_sat flags clamped samples. When undefined, the
//                      sum wraps to OUT_WIDTH bits and out_sat stays 0.

module gauss_fir_mod #(
   parameter int COEF_WIDTH = 5,
   parameter int NUM_TAP    = 17,
   parameter int OUT_WIDTH  = 8,
   localparam int NUM_COEF  = (NUM_TAP + 1) / 2,
   localparam int ADDR_W    = $clog2(NUM_COEF),
   localparam int ACC_W     = COEF_WIDTH + $clog2(NUM_TAP) + 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         coef_wr_en,
   input  logic [ADDR_W-1:0]            coef_wr_addr,
   input  logic signed [COEF_WIDTH-1:0] coef_wr_data,
   input  logic                         bit_in,
   input  logic                         bit_in_valid,
   input  logic                         bit_in_last,
   output logic                         bit_in_ready,
   output logic signed [OUT_WIDTH-1:0]  out_sample,
   output logic                         out_valid,
   output logic                         out_last,
   output logic                         out_sat,
   output logic                         busy
);

   localparam int CNT_W = $clog2(NUM_TAP);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

   state_t                        state_reg;
   logic signed [COEF_WIDTH-1:0]  coef_reg [NUM_COEF];
   logic [NUM_TAP-1:1]            win_reg;
   logic [NUM_TAP-1:1]            mask_reg;
   logic [CNT_W-1:0]              flush_cnt_reg;
   logic                          ready_reg;
   logic                          out_valid_reg;
   logic                          out_last_reg;
   logic signed [OUT_WIDTH-1:0]   out_sample_reg;

   logic                          accept;
   logic                          flush_step;
   logic                          step;
   logic                          flush_done;
   logic                          coef_addr_ok;
   logic [NUM_TAP-1:0]            win_full;
   logic [NUM_TAP-1:0]            mask_full;
   logic signed [ACC_W-1:0]       term [NUM_TAP];
   logic signed [ACC_W-1:0]       acc_sum;
   logic signed [OUT_WIDTH-1:0]   sample_next;

   assign accept       = bit_in_valid && ready_reg;
   assign flush_step   = (state_reg == FLUSH);
   assign step         = accept || flush_step;
   assign flush_done   = flush_step && (flush_cnt_reg == CNT_W'(NUM_TAP - 2));
   assign coef_addr_ok = (32'(coef_wr_addr) < NUM_COEF);

   // Position 0 is the bit being accepted this cycle. During flush it is a
   // masked zero, so the stored history drains out without new data.
   assign win_full  = {win_reg, accept & bit_in};
   assign mask_full = {mask_reg, accept};

   // Per-tap contribution. The symmetric tap k folds onto coef[min(k, N-1-k)].
   generate
      for (genvar gi = 0; gi < NUM_TAP; gi++) begin : g_tap
         localparam int CI = (gi < NUM_TAP - 1 - gi) ? gi : NUM_TAP - 1 - gi;
         logic signed [ACC_W-1:0] coef_ext;
         assign coef_ext = {{(ACC_W - COEF_WIDTH){coef_reg[CI][COEF_WIDTH-1]}}, coef_reg[CI]};
         assign term[gi] = !mask_full[gi] ? '0 : (win_full[gi] ? coef_ext : -coef_ext);
      end
   endgenerate

   // ACC_W is wide enough that this sum of NUM_TAP terms never overflows.
   always_comb begin
      acc_sum = '0;
      for (int k = 0; k < NUM_TAP; k++) begin
         acc_sum = acc_sum + term[k];
      end
   end

`ifdef GAUSS_FIR_SAT_EN
   logic sat_next;
   logic out_sat_reg;

   generate
      if (OUT_WIDTH < ACC_W) begin : g_clamp
         localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (OUT_WIDTH - 1)) - 1);
         localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (OUT_WIDTH - 1)));
         always_comb begin
            sample_next = OUT_WIDTH'(acc_sum);
            sat_next    = 1'b0;
            if (acc_sum > SAT_MAX) begin
               sample_next = SAT_MAX[OUT_WIDTH-1:0];
               sat_next    = 1'b1;
            end else if (acc_sum < SAT_MIN) begin
               sample_next = SAT_MIN[OUT_WIDTH-1:0];
               sat_next    = 1'b1;
            end
         end
      end else begin : g_no_clamp
         // Output is at least as wide as the sum: sign-extend, never clamps.
         assign sample_next = OUT_WIDTH'(acc_sum);
         assign sat_next    = 1'b0;
      end
   endgenerate

   assign out_sat = out_sat_reg;
`else
   // Two's-complement wrap (or sign extension if the output is wider).
   assign sample_next = OUT_WIDTH'(acc_sum);
   assign out_sat     = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= IDLE;
         ready_reg      <= 1'b0;
         win_reg        <= '0;
         mask_reg       <= '0;
         flush_cnt_reg  <= '0;
         out_valid_reg  <= 1'b0;
         out_last_reg   <= 1'b0;
         out_sample_reg <= '0;
`ifdef GAUSS_FIR_SAT_EN
         out_sat_reg    <= 1'b0;
`endif
         for (int k = 0; k < NUM_COEF; k++) begin
            coef_reg[k] <= '0;
         end
      end else begin
         if (coef_wr_en && coef_addr_ok) begin
            coef_reg[coef_wr_addr] <= coef_wr_data;
         end

         out_valid_reg <= step;
         out_last_reg  <= flush_done;
         // Sample (and its saturation flag) hold while no new output is made.
         if (step) begin
            out_sample_reg <= sample_next;
`ifdef GAUSS_FIR_SAT_EN
            out_sat_reg    <= sat_next;
`endif
         end

         case (state_reg)
            IDLE, RUN: begin
               ready_reg <= 1'b1;
               if (accept) begin
                  win_reg       <= win_full[NUM_TAP-2:0];
                  mask_reg      <= mask_full[NUM_TAP-2:0];
                  flush_cnt_reg <= '0;
                  if (bit_in_last) begin
                     state_reg <= FLUSH;
                     ready_reg <= 1'b0;
                  end else begin
                     state_reg <= RUN;
                  end
               end
            end
            FLUSH: begin
               win_reg       <= win_full[NUM_TAP-2:0];
               mask_reg      <= mask_full[NUM_TAP-2:0];
               flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
               if (flush_done) begin
                  // Drop all history so the next packet starts clean.
                  state_reg     <= IDLE;
                  ready_reg     <= 1'b1;
                  win_reg       <= '0;
                  mask_reg      <= '0;
                  flush_cnt_reg <= '0;
               end
            end
            default: begin
               state_reg <= IDLE;
               ready_reg <= 1'b1;
            end
         endcase
      end
   end

   assign bit_in_ready = ready_reg;
   assign out_sample   = out_sample_reg;
   assign out_valid    = out_valid_reg;
   assign out_last     = out_last_reg;
   assign busy         = (state_reg != IDLE);

endmodule
